// File: rtl/vx_dispatch_arbiter_if.sv
// Dispatch handshake bundle between the issue slots and the shared execution lane.
//   valid_in/data_in/ready_in : per-slot request side (slot i at data_in[i*DATAW +: DATAW])
//   valid_out/data_out/idx_out/ready_out : single execution-unit side, idx_out tags the source slot
// The arbiter connects through the slave modport; the environment drives the master modport.
interface vx_dispatch_arbiter_if #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 64
);
    localparam int unsigned IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic [IDXW-1:0]           idx_out;
    logic                      ready_out;

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, idx_out
    );

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, idx_out
    );
endinterface

// File: rtl/vx_dispatch_arbiter.sv
// Round-robin dispatch arbiter: picks one valid slot per cycle and queues it,
// tagged with its slot index, in a 2-entry FIFO feeding the shared execution lane.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   bus          slave side of vx_dispatch_arbiter_if (per-slot requests, FIFO head)
//   perf_stalls  saturating count of cycles with valid_out=1 and ready_out=0
module vx_dispatch_arbiter #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned DATAW    = 64,
    parameter int unsigned CTR_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    vx_dispatch_arbiter_if.slave   bus,
    output logic [CTR_W-1:0]       perf_stalls
);
    localparam int unsigned IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic [DATAW-1:0] data;
    } entry_t;

    logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [CTR_W-1:0]    perf_q, perf_d;
    entry_t              fifo_q [2];

    logic [DATAW-1:0]    slot_data [NUM_REQS];
    logic [NUM_REQS-1:0] grant;
    logic [IDXW-1:0]     grant_idx;
    logic [IDXW-1:0]     cand;
    logic                grant_found;
    logic                can_push;
    logic                fire_in;
    logic                fire_out;

    // Unpack the flat payload bus into per-slot words.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
        assign slot_data[i] = bus.data_in[i*DATAW +: DATAW];
    end

    // Round-robin scan starting at rr_ptr; first valid slot wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        cand        = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            cand = IDXW'((32'(rr_ptr_q) + k) % NUM_REQS);
            if (!grant_found && bus.valid_in[cand]) begin
                grant_found = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign bus.valid_out = (count_q != 2'd0);
    assign bus.data_out  = fifo_q[rd_ptr_q].data;
    assign bus.idx_out   = fifo_q[rd_ptr_q].idx;
    assign perf_stalls   = perf_q;

    assign fire_out = bus.valid_out && bus.ready_out;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign can_push = (count_q != 2'd2) || fire_out;
    // Accepts are blocked during reset so nothing is taken and then flushed.
    assign bus.ready_in = reset ? (grant & {NUM_REQS{can_push}}) : '0;
    assign fire_in  = |(bus.valid_in & bus.ready_in);

    // Next-state for pointers, occupancy and stall counter.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        perf_d   = perf_q;

        if (fire_in) begin
            rr_ptr_d = IDXW'((32'(grant_idx) + 32'd1) % NUM_REQS);
            wr_ptr_d = ~wr_ptr_q;
        end
        if (fire_out) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({fire_in, fire_out})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (bus.valid_out && !bus.ready_out && (perf_q != '1)) begin
            perf_d = perf_q + CTR_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            perf_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            perf_q   <= perf_d;
        end
    end

    // FIFO storage; contents are only meaningful where count marks them valid.
    always_ff @(posedge clk) begin
        if (fire_in) begin
            fifo_q[wr_ptr_q] <= entry_t'{idx: grant_idx, data: slot_data[grant_idx]};
        end
    end
endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Directed bench for vx_dispatch_arbiter: NUM_REQS=4, DATAW=64, CTR_W=4.
module tb_vx_dispatch_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] perf;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    vx_dispatch_arbiter_if #(.NUM_REQS(NR), .DATAW(DW)) bus ();

    vx_dispatch_arbiter #(
        .NUM_REQS (NR),
        .DATAW    (DW),
        .CTR_W    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .perf_stalls (perf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [63:0] base);
        for (int i = 0; i < NR; i++) begin
            bus.data_in[i*DW +: DW] = base + 64'(i);
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.valid_in  = '0;
        bus.ready_out = 1'b0;
        set_data(64'h0);

        // Reset state
        tick();
        tick();
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_perf", 64'(perf), 64'd0);
        bus.valid_in = 4'hF;
        #1;
        chk("rst_ready_in", 64'(bus.ready_in), 64'd0);

        // Single request from slot 2
        reset         = 1'b1;
        bus.ready_out = 1'b1;
        bus.valid_in  = 4'b0100;
        bus.data_in[2*DW +: DW] = 64'hA5;
        #1;
        chk("single_ready_in", 64'(bus.ready_in), 64'b0100);
        tick();
        chk("single_valid", 64'(bus.valid_out), 64'd1);
        chk("single_data", bus.data_out, 64'hA5);
        chk("single_idx", 64'(bus.idx_out), 64'd2);

        // rr_ptr now 3: with every slot valid slot 3 is granted first
        set_data(64'h100);
        bus.valid_in = 4'hF;
        #1;
        chk("rr_after_single", 64'(bus.ready_in), 64'b1000);

        // Round-robin, one output per cycle
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_valid", 64'(bus.valid_out), 64'd1);
            chk("rr_idx", 64'(bus.idx_out), 64'((3 + k) % 4));
            chk("rr_data", bus.data_out, 64'h100 + 64'((3 + k) % 4));
        end
        bus.valid_in = '0;
        tick();
        chk("drain_empty", 64'(bus.valid_out), 64'd0);
        bus.valid_in = 4'hF;
        #1;
        chk("empty_ignores_valid_in", 64'(bus.valid_out), 64'd0);
        bus.valid_in = '0;

        // Restart arbitration from slot 0
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Backpressure: two accepts then full
        bus.ready_out = 1'b0;
        set_data(64'h200);
        bus.valid_in = 4'hF;
        #1;
        chk("bp_ready0", 64'(bus.ready_in), 64'b0001);
        tick();
        chk("bp_valid1", 64'(bus.valid_out), 64'd1);
        chk("bp_idx1", 64'(bus.idx_out), 64'd0);
        chk("bp_data1", bus.data_out, 64'h200);
        chk("bp_ready1", 64'(bus.ready_in), 64'b0010);
        chk("bp_perf1", 64'(perf), 64'd0);
        tick();
        chk("bp_full_ready", 64'(bus.ready_in), 64'd0);
        chk("bp_idx2", 64'(bus.idx_out), 64'd0);
        chk("bp_data2", bus.data_out, 64'h200);
        chk("bp_perf2", 64'(perf), 64'd1);
        tick();
        chk("bp_full_ready3", 64'(bus.ready_in), 64'd0);
        chk("bp_idx3", 64'(bus.idx_out), 64'd0);
        chk("bp_perf3", 64'(perf), 64'd2);
        tick();
        chk("bp_data4", bus.data_out, 64'h200);
        chk("bp_perf4", 64'(perf), 64'd3);

        // Release: pop and push overlap on a full FIFO (rr_ptr=2)
        bus.ready_out = 1'b1;
        #1;
        chk("rel_ready_in", 64'(bus.ready_in), 64'b0100);
        tick();
        chk("rel_idx1", 64'(bus.idx_out), 64'd1);
        chk("rel_data1", bus.data_out, 64'h201);
        chk("rel_perf", 64'(perf), 64'd3);

        // Full FIFO, rr_ptr=3, slot 3 alone valid
        bus.valid_in = 4'b1000;
        #1;
        chk("full_pp_ready", 64'(bus.ready_in), 64'b1000);
        tick();
        chk("full_pp_idx", 64'(bus.idx_out), 64'd2);
        chk("full_pp_data", bus.data_out, 64'h202);
        bus.valid_in = '0;
        tick();
        chk("full_pp_valid_tail", 64'(bus.valid_out), 64'd1);
        chk("full_pp_idx_tail", 64'(bus.idx_out), 64'd3);
        chk("full_pp_data_tail", bus.data_out, 64'h203);
        tick();
        chk("full_pp_drained", 64'(bus.valid_out), 64'd0);

        // Fill to 2 entries with perf_stalls=5
        bus.valid_in  = 4'hF;
        bus.ready_out = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_perf", 64'(perf), 64'd5);
        chk("pre_rst_ready", 64'(bus.ready_in), 64'd0);
        chk("pre_rst_valid", 64'(bus.valid_out), 64'd1);

        // Reset mid-operation
        bus.ready_out = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready_in", 64'(bus.ready_in), 64'd0);
        tick();
        chk("mid_rst_valid", 64'(bus.valid_out), 64'd0);
        chk("mid_rst_perf", 64'(perf), 64'd0);
        chk("mid_rst_ready_in2", 64'(bus.ready_in), 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_grant", 64'(bus.ready_in), 64'b0001);
        tick();
        chk("post_rst_valid", 64'(bus.valid_out), 64'd1);
        chk("post_rst_idx", 64'(bus.idx_out), 64'd0);
        chk("post_rst_data", bus.data_out, 64'h200);

        // Counter saturation at 15
        bus.valid_in  = '0;
        bus.ready_out = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) chk("sat_perf14", 64'(perf), 64'd14);
            if (n == 15) chk("sat_perf15", 64'(perf), 64'd15);
        end
        chk("sat_perf20", 64'(perf), 64'd15);
        chk("sat_idx_stable", 64'(bus.idx_out), 64'd0);
        chk("sat_data_stable", bus.data_out, 64'h200);
        chk("sat_valid", 64'(bus.valid_out), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
